// File: rtl/wts_env_pkg.sv
// rtl/wts_env_pkg.sv - shared state codes and sustain target helper for the ADSR envelope generator
package wts_env_pkg;
  localparam int ST_W = 3;

  localparam logic [ST_W-1:0] ST_IDLE    = 3'd0;
  localparam logic [ST_W-1:0] ST_ATTACK  = 3'd1;
  localparam logic [ST_W-1:0] ST_DECAY   = 3'd2;
  localparam logic [ST_W-1:0] ST_SUSTAIN = 3'd3;
  localparam logic [ST_W-1:0] ST_RELEASE = 3'd4;

  // 6-bit sustain level scaled up to the full level range
  function automatic logic [15:0] sustain_target(input logic [5:0] sl, input int level_w);
    return {10'd0, sl} << (level_w - 6);
  endfunction
endpackage

// File: rtl/wts_adsr_envelope_step.sv
// rtl/wts_adsr_envelope_step.sv - combinational next-state core for one envelope channel; honours WTS_ADSR_HARD_RETRIGGER_EN
module wts_adsr_envelope_step
  import wts_env_pkg::*;
#(
  parameter int LEVEL_W   = 7,
  parameter int COUNTER_W = 16
) (
  input  logic [ST_W-1:0]      state,
  input  logic [COUNTER_W-1:0] counter,
  input  logic [LEVEL_W-1:0]   level,
  input  logic [7:0]           ar,
  input  logic [7:0]           dr,
  input  logic [7:0]           sr,
  input  logic [7:0]           rr,
  input  logic [5:0]           sl,
  input  logic                 ev_on,
  input  logic                 ev_rel,
  input  logic                 ev_off,
  output logic [ST_W-1:0]      nxt_state,
  output logic [COUNTER_W-1:0] nxt_counter,
  output logic [LEVEL_W-1:0]   nxt_level
);
  localparam logic [LEVEL_W-1:0] MAX = '1;

  logic [7:0]           rate;
  logic [COUNTER_W:0]   sum;
  logic                 step;
  logic [15:0]          target;
  logic                 above_target;
  logic                 rel_ok;

  always_comb begin
    case (state)
      ST_ATTACK:  rate = ar;
      ST_DECAY:   rate = dr;
      ST_SUSTAIN: rate = sr;
      ST_RELEASE: rate = rr;
      default:    rate = 8'd0;
    endcase
  end

  assign sum          = {1'b0, counter} + {{(COUNTER_W-7){1'b0}}, rate};
  assign step         = sum[COUNTER_W];
  assign target       = sustain_target(sl, LEVEL_W);
  assign above_target = {{(16-LEVEL_W){1'b0}}, level} > target;
  assign rel_ok       = (state == ST_ATTACK) || (state == ST_DECAY) || (state == ST_SUSTAIN);

  always_comb begin
    nxt_state   = state;
    nxt_counter = sum[COUNTER_W-1:0];
    nxt_level   = level;
    if (ev_off) begin
      nxt_state   = ST_IDLE;
      nxt_counter = '0;
      nxt_level   = '0;
    end else if (ev_on) begin
      nxt_state   = ST_ATTACK;
      nxt_counter = '0;
`ifdef WTS_ADSR_HARD_RETRIGGER_EN
      nxt_level   = '0;
`else
      nxt_level   = level;
`endif
    end else if (ev_rel && rel_ok) begin
      nxt_state   = ST_RELEASE;
      nxt_counter = '0;
    end else begin
      case (state)
        ST_ATTACK: begin
          if (level == MAX) begin
            nxt_state   = ST_DECAY;
            nxt_counter = '0;
          end else if (step) begin
            nxt_level = level + 1'b1;
          end
        end
        ST_DECAY: begin
          // above_target implies level > 0, so the decrement cannot wrap
          if (!above_target) begin
            nxt_state   = ST_SUSTAIN;
            nxt_counter = '0;
          end else if (step) begin
            nxt_level = level - 1'b1;
          end
        end
        ST_SUSTAIN: begin
          if (step && (level != '0)) nxt_level = level - 1'b1;
        end
        ST_RELEASE: begin
          if (level == '0) begin
            nxt_state   = ST_IDLE;
            nxt_counter = '0;
          end else if (step) begin
            nxt_level = level - 1'b1;
          end
        end
        default: begin
          nxt_state   = ST_IDLE;
          nxt_counter = '0;
          nxt_level   = '0;
        end
      endcase
    end
  end
endmodule

// File: rtl/wts_adsr_envelope_generator_mch.sv
// rtl/wts_adsr_envelope_generator_mch.sv - time-multiplexed multi-channel ADSR envelope generator; WTS_ADSR_HARD_RETRIGGER_EN selects hard retrigger
module wts_adsr_envelope_generator_mch
  import wts_env_pkg::*;
#(
  parameter int CHANNELS  = 5,
  parameter int LEVEL_W   = 7,
  parameter int COUNTER_W = 16,
  parameter int CH_W      = $clog2(CHANNELS + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [CH_W-1:0]       active,
  input  logic [CHANNELS-1:0]   key_on,
  input  logic [CHANNELS-1:0]   key_release,
  input  logic [CHANNELS-1:0]   key_off,
  input  logic [8*CHANNELS-1:0] reg_ar,
  input  logic [8*CHANNELS-1:0] reg_dr,
  input  logic [8*CHANNELS-1:0] reg_sr,
  input  logic [8*CHANNELS-1:0] reg_rr,
  input  logic [6*CHANNELS-1:0] reg_sl,
  output logic [LEVEL_W-1:0]    envelope,
  output logic [CH_W-1:0]       envelope_ch,
  output logic                  envelope_valid
);
  logic [ST_W-1:0]      st_q  [CHANNELS];
  logic [COUNTER_W-1:0] cnt_q [CHANNELS];
  logic [LEVEL_W-1:0]   lvl_q [CHANNELS];
  logic [CHANNELS-1:0]  pend_on_q, pend_rel_q, pend_off_q;

  logic [CHANNELS-1:0]  svc;
  logic                 svc_valid;
  logic [ST_W-1:0]      cur_st, nxt_st;
  logic [COUNTER_W-1:0] cur_cnt, nxt_cnt;
  logic [LEVEL_W-1:0]   cur_lvl, nxt_lvl;
  logic [7:0]           cur_ar, cur_dr, cur_sr, cur_rr;
  logic [5:0]           cur_sl;
  logic                 ev_on, ev_rel, ev_off;

  // one-hot service select; out-of-range active leaves it all-zero
  always_comb begin
    svc = '0;
    for (int i = 0; i < CHANNELS; i++) svc[i] = (active == CH_W'(i));
  end
  assign svc_valid = |svc;

  always_comb begin
    cur_st  = ST_IDLE;
    cur_cnt = '0;
    cur_lvl = '0;
    cur_ar  = '0;
    cur_dr  = '0;
    cur_sr  = '0;
    cur_rr  = '0;
    cur_sl  = '0;
    ev_on   = 1'b0;
    ev_rel  = 1'b0;
    ev_off  = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (svc[i]) begin
        cur_st  = st_q[i];
        cur_cnt = cnt_q[i];
        cur_lvl = lvl_q[i];
        cur_ar  = reg_ar[8*i +: 8];
        cur_dr  = reg_dr[8*i +: 8];
        cur_sr  = reg_sr[8*i +: 8];
        cur_rr  = reg_rr[8*i +: 8];
        cur_sl  = reg_sl[6*i +: 6];
        ev_on   = pend_on_q[i]  | key_on[i];
        ev_rel  = pend_rel_q[i] | key_release[i];
        ev_off  = pend_off_q[i] | key_off[i];
      end
    end
  end

  wts_adsr_envelope_step #(
    .LEVEL_W   (LEVEL_W),
    .COUNTER_W (COUNTER_W)
  ) u_step (
    .state       (cur_st),
    .counter     (cur_cnt),
    .level       (cur_lvl),
    .ar          (cur_ar),
    .dr          (cur_dr),
    .sr          (cur_sr),
    .rr          (cur_rr),
    .sl          (cur_sl),
    .ev_on       (ev_on),
    .ev_rel      (ev_rel),
    .ev_off      (ev_off),
    .nxt_state   (nxt_st),
    .nxt_counter (nxt_cnt),
    .nxt_level   (nxt_lvl)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        st_q[i]  <= ST_IDLE;
        cnt_q[i] <= '0;
        lvl_q[i] <= '0;
      end
      pend_on_q      <= '0;
      pend_rel_q     <= '0;
      pend_off_q     <= '0;
      envelope       <= '0;
      envelope_ch    <= '0;
      envelope_valid <= 1'b0;
    end else begin
      // the serviced channel consumes both its latch and any same-cycle pulse
      pend_on_q  <= (pend_on_q  | key_on)      & ~svc;
      pend_rel_q <= (pend_rel_q | key_release) & ~svc;
      pend_off_q <= (pend_off_q | key_off)     & ~svc;
      for (int i = 0; i < CHANNELS; i++) begin
        if (svc[i]) begin
          st_q[i]  <= nxt_st;
          cnt_q[i] <= nxt_cnt;
          lvl_q[i] <= nxt_lvl;
        end
      end
      envelope_valid <= svc_valid;
      if (svc_valid) begin
        envelope    <= nxt_lvl;
        envelope_ch <= active;
      end
    end
  end
endmodule

// File: tb/tb_wts_adsr_envelope_generator_mch.sv
// tb/tb_wts_adsr_envelope_generator_mch.sv - directed self-checking bench for the multi-channel ADSR generator
module tb_wts_adsr_envelope_generator_mch;
  localparam int CHANNELS  = 5;
  localparam int LEVEL_W   = 7;
  localparam int COUNTER_W = 8;
  localparam int CH_W      = 3;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [CH_W-1:0]       active;
  logic [CHANNELS-1:0]   key_on, key_release, key_off;
  logic [8*CHANNELS-1:0] reg_ar, reg_dr, reg_sr, reg_rr;
  logic [6*CHANNELS-1:0] reg_sl;
  logic [LEVEL_W-1:0]    envelope;
  logic [CH_W-1:0]       envelope_ch;
  logic                  envelope_valid;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  wts_adsr_envelope_generator_mch #(
    .CHANNELS  (CHANNELS),
    .LEVEL_W   (LEVEL_W),
    .COUNTER_W (COUNTER_W),
    .CH_W      (CH_W)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .active         (active),
    .key_on         (key_on),
    .key_release    (key_release),
    .key_off        (key_off),
    .reg_ar         (reg_ar),
    .reg_dr         (reg_dr),
    .reg_sr         (reg_sr),
    .reg_rr         (reg_rr),
    .reg_sl         (reg_sl),
    .envelope       (envelope),
    .envelope_ch    (envelope_ch),
    .envelope_valid (envelope_valid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // one clock with the given active; key pulses last exactly this cycle
  task automatic service(input int a);
    active = CH_W'(a);
    @(posedge clk);
    #1;
    key_on      = '0;
    key_release = '0;
    key_off     = '0;
  endtask

  task automatic run(input int a, input int n);
    for (int k = 0; k < n; k++) service(a);
  endtask

  initial begin
    reset       = 1'b1;
    active      = 3'd7;
    key_on      = '0;
    key_release = '0;
    key_off     = '0;
    reg_ar = {8'hFF, 8'hFF, 8'h80, 8'hFF, 8'hFF};
    reg_dr = {8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF};
    reg_sr = '0;
    reg_rr = {8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
    reg_sl = {6'd0, 6'd0, 6'd0, 6'd20, 6'd45};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_env", 32'(envelope), 0);
    chk("rst_ch", 32'(envelope_ch), 0);
    chk("rst_valid", 32'(envelope_valid), 0);
    reset = 1'b0;

    for (int c = 0; c < CHANNELS; c++) begin
      service(c);
      chk("cyc_valid", 32'(envelope_valid), 1);
      chk("cyc_env", 32'(envelope), 0);
      chk("cyc_ch", 32'(envelope_ch), 32'(c));
    end

    // ch2 attack at half rate, key_on latched while ch0 is serviced
    key_on[2] = 1'b1;
    service(0);
    chk("ch2_pend_ch", 32'(envelope_ch), 0);
    service(2);
    chk("ch2_on", 32'(envelope), 0);
    run(2, 99);
    chk("ch2_s99", 32'(envelope), 49);
    run(2, 154);
    chk("ch2_s253", 32'(envelope), 126);
    service(2);
    chk("ch2_s254_max", 32'(envelope), 127);
    service(2);
    chk("ch2_s255_max", 32'(envelope), 127);
    run(2, 2);
    chk("ch2_decay", 32'(envelope), 126);

    // ch1 attack then decay to sl=20 -> 40
    key_on[1] = 1'b1;
    service(1);
    chk("ch1_on", 32'(envelope), 0);
    run(1, 128);
    chk("ch1_max", 32'(envelope), 127);
    run(1, 3);
    chk("ch1_dec1", 32'(envelope), 126);
    run(1, 85);
    chk("ch1_s216", 32'(envelope), 41);
    service(1);
    chk("ch1_s217", 32'(envelope), 40);
    service(1);
    chk("ch1_sus_entry", 32'(envelope), 40);
    run(1, 10);
    chk("ch1_sus_hold", 32'(envelope), 40);

    // ch3 simultaneous on+off, off wins
    key_on[3] = 1'b1;
    service(3);
    run(3, 10);
    chk("ch3_s10", 32'(envelope), 9);
    key_on[3]  = 1'b1;
    key_off[3] = 1'b1;
    service(7);
    chk("ch3_noop_valid", 32'(envelope_valid), 0);
    service(3);
    chk("ch3_off", 32'(envelope), 0);
    run(3, 2);
    chk("ch3_idle", 32'(envelope), 0);

    // ch4 release to idle, then out-of-range active
    key_on[4] = 1'b1;
    service(4);
    run(4, 10);
    chk("ch4_s10", 32'(envelope), 9);
    key_release[4] = 1'b1;
    service(7);
    chk("ch4_noop_valid", 32'(envelope_valid), 0);
    chk("ch4_noop_env", 32'(envelope), 9);
    chk("ch4_noop_ch", 32'(envelope_ch), 4);
    service(4);
    chk("ch4_rel", 32'(envelope), 9);
    run(4, 2);
    chk("ch4_rel_s2", 32'(envelope), 8);
    run(4, 8);
    chk("ch4_rel_s10", 32'(envelope), 0);
    service(4);
    chk("ch4_idle", 32'(envelope), 0);
    service(5);
    chk("act5_valid", 32'(envelope_valid), 0);
    chk("act5_env", 32'(envelope), 0);
    chk("act5_ch", 32'(envelope_ch), 4);

    // ch0 to sustain at 90, then retrigger
    key_on[0] = 1'b1;
    service(0);
    run(0, 166);
    chk("ch0_s166", 32'(envelope), 91);
    run(0, 2);
    chk("ch0_sus", 32'(envelope), 90);
    run(0, 2);
    chk("ch0_sus_hold", 32'(envelope), 90);
    key_on[0] = 1'b1;
    service(0);
`ifdef WTS_ADSR_HARD_RETRIGGER_EN
    chk("ch0_retrig", 32'(envelope), 0);
    run(0, 2);
    chk("ch0_retrig_s2", 32'(envelope), 1);
`else
    chk("ch0_retrig", 32'(envelope), 90);
    run(0, 2);
    chk("ch0_retrig_s2", 32'(envelope), 91);
`endif

    // async reset mid-cycle drops a latched key_on
    key_on[0] = 1'b1;
    service(7);
    reset = 1'b1;
    #2;
    chk("arst_env", 32'(envelope), 0);
    chk("arst_valid", 32'(envelope_valid), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    service(0);
    chk("arst_svc", 32'(envelope), 0);
    run(0, 2);
    chk("arst_no_pend", 32'(envelope), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
